// File: rtl/lut_neuron_pkg.sv
// Shared constants and state type for the reprogrammable LUT neuron.
package lut_neuron_pkg;

    localparam int unsigned IN_BITS  = 6;
    localparam int unsigned OUT_BITS = 2;
    localparam int unsigned DEPTH    = 2 ** IN_BITS;

    localparam logic [IN_BITS-1:0] LastAddr = IN_BITS'(DEPTH - 1);

    typedef enum logic [1:0] {
        StEmpty,
        StLoad,
        StReady
    } state_e;

endpackage

// File: rtl/lut_neuron_table.sv
// DEPTH x OUT_BITS truth table: synchronous write, asynchronous read, cleared on reset.
module lut_neuron_table
    import lut_neuron_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we_i,
    input  logic [IN_BITS-1:0]  waddr_i,
    input  logic [OUT_BITS-1:0] wdata_i,
    input  logic [IN_BITS-1:0]  raddr_i,
    output logic [OUT_BITS-1:0] rdata_o
);

    logic [OUT_BITS-1:0] mem_q [DEPTH];

    // Storage: every entry returns to 0 on reset so a partial load never leaks old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lut_neuron_loader.sv
// Run-time reprogrammable LUT neuron: config-stream table writer plus registered lookup.
module lut_neuron_loader
    import lut_neuron_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [OUT_BITS-1:0] cfg_data,
    output logic                cfg_done,
    output logic                tbl_loaded,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_BITS-1:0]  M0,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] M1
);

    state_e              state_q, state_d;
    logic [IN_BITS-1:0]  addr_q, addr_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic                in_ready_q, in_ready_d;
    logic                cfg_done_q, cfg_done_d;
    logic                out_valid_q, out_valid_d;
    logic [OUT_BITS-1:0] m1_q, m1_d;

    logic                wr_en;
    logic                rd_fire;
    logic [OUT_BITS-1:0] rd_data;

    // cfg_start overrides a coincident write; the lookup side is independent of it.
    assign wr_en   = cfg_valid && cfg_ready_q && !cfg_start;
    assign rd_fire = in_valid && in_ready_q;

    lut_neuron_table u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_en),
        .waddr_i (addr_q),
        .wdata_i (cfg_data),
        .raddr_i (M0),
        .rdata_o (rd_data)
    );

    // Next-state: load sequencing, address counter, handshake and lookup output register.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cfg_done_d  = 1'b0;
        out_valid_d = rd_fire;
        m1_d        = rd_fire ? rd_data : m1_q;

        if (cfg_start) begin
            state_d = StLoad;
            addr_d  = '0;
        end else if (wr_en) begin
            addr_d = addr_q + 1'b1;
            if (addr_q == LastAddr) begin
                state_d    = StReady;
                cfg_done_d = 1'b1;
            end
        end

        // Handshake outputs are registered from the next state so they track state_q exactly.
        cfg_ready_d = (state_d == StLoad);
        in_ready_d  = (state_d == StReady);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            addr_q      <= '0;
            cfg_ready_q <= 1'b0;
            in_ready_q  <= 1'b0;
            cfg_done_q  <= 1'b0;
            out_valid_q <= 1'b0;
            m1_q        <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cfg_ready_q <= cfg_ready_d;
            in_ready_q  <= in_ready_d;
            cfg_done_q  <= cfg_done_d;
            out_valid_q <= out_valid_d;
            m1_q        <= m1_d;
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign in_ready   = in_ready_q;
    assign tbl_loaded = in_ready_q;
    assign cfg_done   = cfg_done_q;
    assign out_valid  = out_valid_q;
    assign M1         = m1_q;

endmodule

// File: tb/tb_lut_neuron_loader.sv
// Self-checking bench for lut_neuron_loader against a behavioural table model.
module tb_lut_neuron_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_start;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_data;
    logic       cfg_done;
    logic       tbl_loaded;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] M0;
    logic       out_valid;
    logic [1:0] M1;

    int errors = 0;
    int checks = 0;

    // Reference: what the table should hold.
    logic [1:0] model [64];

    always #5 clk = ~clk;

    lut_neuron_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_start  (cfg_start),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
        .cfg_done   (cfg_done),
        .tbl_loaded (tbl_loaded),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .M0         (M0),
        .out_valid  (out_valid),
        .M1         (M1)
    );

    // Pattern: (a[5:4]+a[3:2]+a[1:0])>>1, saturated at 3.
    function automatic logic [1:0] fval(input int a);
        int s;
        s = ((a >> 4) & 3) + ((a >> 2) & 3) + (a & 3);
        s = s >> 1;
        if (s > 3) s = 3;
        return 2'(s);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++; $display("FAIL start_cfg_ready got=%0b exp=1", cfg_ready);
        end
    endtask

    // Stream 64 entries (mode 0: pattern, 1: random, 2: zeros) with lookups held off.
    task automatic load_entries(input int mode, input bit gaps);
        int n = 0;
        int cyc = 0;
        logic v;
        logic [1:0] d;
        in_valid = 1'b1;
        while (n < 64 && cyc < 2000) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            d = (mode == 0) ? fval(n) : (mode == 1) ? 2'($urandom_range(0, 3)) : 2'b00;
            M0 = 6'($urandom);
            cfg_valid = v;
            cfg_data  = d;
            checks++;
            if (cfg_ready !== 1'b1 || tbl_loaded !== 1'b0 || in_ready !== 1'b0
                || cfg_done !== 1'b0) begin
                errors++;
                $display("FAIL load_status n=%0d got rdy=%0b ld=%0b inr=%0b done=%0b exp 1,0,0,0",
                         n, cfg_ready, tbl_loaded, in_ready, cfg_done);
            end
            if (cyc > 0) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++; $display("FAIL load_out_valid n=%0d got=%0b exp=0", n, out_valid);
                end
            end
            step();
            if (v) begin
                model[n] = d;
                n++;
            end
            cyc++;
        end
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (n != 64) begin
            errors++; $display("FAIL load_timeout got=%0d writes exp=64", n);
        end
        checks++;
        if (cfg_done !== 1'b1 || tbl_loaded !== 1'b1 || in_ready !== 1'b1 || cfg_ready !== 1'b0)
        begin
            errors++;
            $display("FAIL load_end got done=%0b ld=%0b inr=%0b rdy=%0b exp 1,1,1,0",
                     cfg_done, tbl_loaded, in_ready, cfg_ready);
        end
        step();
        checks++;
        if (cfg_done !== 1'b0 || tbl_loaded !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_after got done=%0b ld=%0b ov=%0b exp 0,1,0",
                     cfg_done, tbl_loaded, out_valid);
        end
    endtask

    task automatic do_lookup(input logic [5:0] a);
        in_valid = 1'b1;
        M0 = a;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL lookup_in_ready addr=%0d got=%0b exp=1", a, in_ready);
        end
        step();
        in_valid = 1'b0;
        M0 = ~a;
        checks++;
        if (out_valid !== 1'b1 || M1 !== model[a]) begin
            errors++;
            $display("FAIL lookup addr=%0d got ov=%0b M1=%0d exp ov=1 M1=%0d",
                     a, out_valid, M1, model[a]);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || M1 !== model[a]) begin
            errors++;
            $display("FAIL lookup_hold addr=%0d got ov=%0b M1=%0d exp ov=0 M1=%0d",
                     a, out_valid, M1, model[a]);
        end
    endtask

    // Consecutive lookups of every address, one per cycle.
    task automatic read_all(input string tag);
        in_valid = 1'b1;
        for (int i = 0; i < 65; i++) begin
            if (i < 64) M0 = 6'(i);
            else in_valid = 1'b0;
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || M1 !== model[i-1]) begin
                    errors++;
                    $display("FAIL %s_read addr=%0d got ov=%0b M1=%0d exp ov=1 M1=%0d",
                             tag, i - 1, out_valid, M1, model[i-1]);
                end
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || M1 !== model[63]) begin
            errors++;
            $display("FAIL %s_read_end got ov=%0b M1=%0d exp ov=0 M1=%0d",
                     tag, out_valid, M1, model[63]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0; in_valid = 1'b0; M0 = '0;
        for (int i = 0; i < 64; i++) model[i] = 2'b00;
        #3;
        checks++;
        if ({cfg_ready, cfg_done, tbl_loaded, in_ready, out_valid, M1} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0000000",
                     {cfg_ready, cfg_done, tbl_loaded, in_ready, out_valid, M1});
        end
        step(); step();
        #2 rst_n = 1'b1;
        step();
        in_valid = 1'b1;
        M0 = 6'd5;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || tbl_loaded !== 1'b0) begin
            errors++; $display("FAIL reset_no_lookup got ov=%0b ld=%0b exp 0,0", out_valid,
                               tbl_loaded);
        end
    endtask

    task automatic test_full_load();
        // Spurious cfg_valid in EMPTY must neither write nor advance the address.
        cfg_valid = 1'b1;
        cfg_data  = 2'b11;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cfg_ready !== 1'b0) begin
                errors++; $display("FAIL empty_cfg_ready got=%0b exp=0", cfg_ready);
            end
            step();
        end
        cfg_valid = 1'b0;
        pulse_start();
        load_entries(0, 1'b0);
        do_lookup(6'b101100);
        do_lookup(6'b000000);
        do_lookup(6'b111111);
        // cfg_valid while READY is ignored.
        cfg_valid = 1'b1;
        cfg_data  = ~model[0];
        step(); step();
        cfg_valid = 1'b0;
        do_lookup(6'b000000);
        do_lookup(6'b000001);
    endtask

    task automatic test_back_to_back();
        pulse_start();
        load_entries(1, 1'b1);
        read_all("b2b");
    endtask

    task automatic test_reload_collision();
        pulse_start();
        load_entries(0, 1'b0);
        cfg_start = 1'b1;
        in_valid  = 1'b1;
        M0        = 6'b100100;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL coll_in_ready got=%0b exp=1", in_ready);
        end
        step();
        cfg_start = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || M1 !== model[36]) begin
            errors++;
            $display("FAIL coll_lookup got ov=%0b M1=%0d exp ov=1 M1=%0d", out_valid, M1, model[36]);
        end
        checks++;
        if (tbl_loaded !== 1'b0 || in_ready !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL coll_state got ld=%0b inr=%0b rdy=%0b exp 0,0,1",
                     tbl_loaded, in_ready, cfg_ready);
        end
        load_entries(1, 1'b1);
        read_all("coll");
    endtask

    task automatic test_restart();
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = 2'($urandom_range(0, 3));
            step();
        end
        // Restart coinciding with a valid beat: that beat is dropped.
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 2'b11;
        step();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        load_entries(0, 1'b1);
        read_all("restart");
    endtask

    task automatic test_reset_mid_load();
        do_lookup(6'b111111);
        pulse_start();
        for (int i = 0; i < 30; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = 2'($urandom_range(1, 3));
            step();
        end
        cfg_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) model[i] = 2'b00;
        checks++;
        if ({cfg_ready, cfg_done, tbl_loaded, in_ready, out_valid, M1} !== 7'b0) begin
            errors++;
            $display("FAIL midload_reset got=%b exp=0000000",
                     {cfg_ready, cfg_done, tbl_loaded, in_ready, out_valid, M1});
        end
        #2 rst_n = 1'b1;
        step();
        checks++;
        if (cfg_ready !== 1'b0 || tbl_loaded !== 1'b0) begin
            errors++;
            $display("FAIL midload_empty got rdy=%0b ld=%0b exp 0,0", cfg_ready, tbl_loaded);
        end
        pulse_start();
        load_entries(2, 1'b0);
        read_all("zeros");
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_back_to_back();
        test_reload_collision();
        test_restart();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case a task ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
